// File: rtl/expr_pkg.sv
// expr_pkg: shared defaults and FSM state type for the multiply sequencer.
// Provides DEF_WIDTH, DEF_MUL_RST, DEF_MUL_LAT and seq_state_t.
package expr_pkg;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MUL_RST = 10;
    localparam int DEF_MUL_LAT = 21;
    typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT, EMIT, DONE} seq_state_t;
endpackage

// File: rtl/operand_ram.sv
// operand_ram: DEPTH x WIDTH operand store, synchronous write, two asynchronous read ports, no reset.
// Ports: clk, we/waddr/wdata write port, raddr_a/rdata_a and raddr_b/rdata_b read ports.
module operand_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_a,
    output logic [WIDTH-1:0]         rdata_b
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we) mem_q[waddr] <= wdata;
    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/expr_mul_sequencer.sv
// expr_mul_sequencer: feeds operand pairs to an iterative multiplier and accumulates the products.
// Ports: clk/reset; wr_en/wr_addr/wr_data operand writes and start/pair_count control (IDLE only);
// busy/done status; mul_x/mul_y/mul_reset/mul_out multiplier link; res_valid/res_data/res_index/acc results.
module expr_mul_sequencer import expr_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 8,
    parameter int MUL_RST = DEF_MUL_RST,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH/2):0]   pair_count,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           mul_x,
    output logic [WIDTH-1:0]           mul_y,
    output logic                       mul_reset,
    input  logic [WIDTH-1:0]           mul_out,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(DEPTH/2)-1:0] res_index,
    output logic [WIDTH-1:0]           acc
);
    localparam int PW  = $clog2(DEPTH / 2);
    localparam int PCW = PW + 1;
    localparam int CW  = $clog2((MUL_RST > MUL_LAT ? MUL_RST : MUL_LAT) + 1);

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pair_q, pair_d, last_q, last_d, res_index_q, res_index_d;
    logic [WIDTH-1:0] mul_x_q, mul_x_d, mul_y_q, mul_y_d;
    logic [WIDTH-1:0] res_data_q, res_data_d, acc_q, acc_d;
    logic [WIDTH-1:0] ram_x, ram_y;
    logic [PCW-1:0]   pc;

    operand_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we      (wr_en && state_q == IDLE),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a ({pair_q, 1'b0}),
        .raddr_b ({pair_q, 1'b1}),
        .rdata_a (ram_x),
        .rdata_b (ram_y)
    );

    assign pc = pair_count > PCW'(DEPTH / 2) ? PCW'(DEPTH / 2) : pair_count;

    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        last_d      = last_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: if (start) begin
                pair_d  = '0;
                last_d  = PW'(pc - PCW'(1));
                acc_d   = '0;
                state_d = pc == '0 ? DONE : CLR;
            end
            CLR: if (cnt_q == CW'(MUL_RST - 1)) begin
                state_d = LOAD;
                mul_x_d = ram_x;
                mul_y_d = ram_y;
            end
            LOAD: state_d = WAIT;
            WAIT: if (cnt_q == CW'(MUL_LAT - 1)) begin
                state_d     = EMIT;
                res_data_d  = mul_out;
                res_index_d = pair_q;
                acc_d       = acc_q + mul_out;
            end
            EMIT: begin
                state_d = pair_q == last_q ? DONE : CLR;
                pair_d  = pair_q + PW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The shared counter restarts on every state change, so each timed state counts from zero.
        cnt_d = state_d != state_q ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pair_q      <= '0;
            last_q      <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            res_data_q  <= '0;
            res_index_q <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pair_q      <= pair_d;
            last_q      <= last_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            acc_q       <= acc_d;
        end
    end

    // Status strobes decode straight from the state register; none depend on mul_out.
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign res_valid = state_q == EMIT;
    assign mul_reset = state_q == IDLE || state_q == CLR || state_q == DONE;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign res_data  = res_data_q;
    assign res_index = res_index_q;
    assign acc       = acc_q;
endmodule

// File: tb/tb_expr_mul_sequencer.sv
// tb_expr_mul_sequencer: scoreboard bench for expr_mul_sequencer with a behavioural slow multiplier.
module tb_expr_mul_sequencer;
    logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [2:0]  wr_addr = '0, pair_count = '0;
    logic [15:0] wr_data = '0;
    logic        busy, done, mul_reset, res_valid;
    logic [15:0] mul_x, mul_y, mul_out, res_data, acc;
    logic [1:0]  res_index;

    expr_mul_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .pair_count(pair_count), .busy(busy), .done(done),
        .mul_x(mul_x), .mul_y(mul_y), .mul_reset(mul_reset), .mul_out(mul_out),
        .res_valid(res_valid), .res_data(res_data), .res_index(res_index), .acc(acc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: garbage until 12 cycles out of reset, then the truncated product.
    logic [4:0] m_cnt = '0;
    always @(posedge clk)
        if (mul_reset) m_cnt <= '0;
        else if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
    assign mul_out = m_cnt >= 5'd12 ? 16'(mul_x * mul_y) : 16'hBAD0;

    int checks = 0, errors = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  idx;
        logic [15:0] a;
        int          c;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic push(input logic [15:0] d, input logic [1:0] idx, input logic [15:0] a, input int c);
        exp_t e;
        e.d = d; e.idx = idx; e.a = a; e.c = c;
        sbq.push_back(e);
    endtask

    always @(negedge clk)
        if (res_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res_valid: got res_data=%0h at cycle %0d, expected no strobe", res_data, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("res_data", 32'(res_data), 32'(mon_e.d));
                chk("res_index", 32'(res_index), 32'(mon_e.idx));
                chk("acc", 32'(acc), 32'(mon_e.a));
                chk("res_cycle", cyc, mon_e.c);
            end
        end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns t1: the cycle value seen in the first cycle after the start edge.
    task automatic run(input logic [2:0] pc, input bit w, input logic [2:0] wa, input logic [15:0] wd, output int t1);
        start = 1'b1; pair_count = pc; wr_en = w; wr_addr = wa; wr_data = wd;
        t1 = cyc + 1;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input int exp_c);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done at cycle %0d", exp_c);
        end else chk("done_cycle", cyc, exp_c);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_mul_reset", 32'(mul_reset), 1);
        chk("rst_mul_x", 32'(mul_x), 0);
        chk("rst_mul_y", 32'(mul_y), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_index", 32'(res_index), 0);
        chk("rst_acc", 32'(acc), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // Single pair 3*2
        wr(0, 16'd3); wr(1, 16'd2);
        run(1, 0, 0, 0, t);
        push(16'd6, 0, 16'd6, t + 32);
        chk("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            chk("clr_mul_reset", 32'(mul_reset), 1);
            @(negedge clk);
        end
        chk("load_mul_reset", 32'(mul_reset), 0);
        chk("load_mul_x", 32'(mul_x), 3);
        chk("load_mul_y", 32'(mul_y), 2);
        wait_done(t + 33);
        chk("acc_hold", 32'(acc), 6);

        // Two pairs {3,2,3,6}
        wr(2, 16'd3); wr(3, 16'd6);
        run(2, 0, 0, 0, t);
        push(16'd6, 0, 16'd6, t + 32);
        push(16'd18, 1, 16'd24, t + 65);
        wait_done(t + 66);

        // Wrap {FFFF,1,2,1}
        wr(0, 16'hFFFF); wr(1, 16'd1); wr(2, 16'd2); wr(3, 16'd1);
        run(2, 0, 0, 0, t);
        push(16'hFFFF, 0, 16'hFFFF, t + 32);
        push(16'd2, 1, 16'h0001, t + 65);
        wait_done(t + 66);
        chk("acc_wrap_hold", 32'(acc), 32'h0001);

        // Zero pairs
        run(0, 0, 0, 0, t);
        chk("zero_done_now", 32'(done), 1);
        chk("zero_acc", 32'(acc), 0);
        wait_done(t);

        // pair_count 7 clamps to 4
        wr(4, 16'd5); wr(5, 16'd5); wr(6, 16'd7); wr(7, 16'd1);
        run(7, 0, 0, 0, t);
        push(16'hFFFF, 0, 16'hFFFF, t + 32);
        push(16'd2, 1, 16'h0001, t + 65);
        push(16'h0019, 2, 16'h001A, t + 98);
        push(16'd7, 3, 16'h0021, t + 131);
        wait_done(t + 132);

        // start/wr_en during WAIT are ignored
        run(1, 0, 0, 0, t);
        push(16'hFFFF, 0, 16'hFFFF, t + 32);
        wait_cyc(t + 15);
        start = 1'b1; pair_count = 3'd4; wr_en = 1'b1; wr_addr = 0; wr_data = 16'd9;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        chk("busy_in_wait", 32'(busy), 1);
        wait_done(t + 33);
        run(1, 0, 0, 0, t);
        push(16'hFFFF, 0, 16'hFFFF, t + 32);
        wait_done(t + 33);

        // start and write in the same IDLE cycle: write lands first
        run(1, 1, 1, 16'd3, t);
        push(16'hFFFD, 0, 16'hFFFD, t + 32);
        wait_done(t + 33);

        // reset during WAIT of pair 1 of 2
        run(2, 0, 0, 0, t);
        push(16'hFFFD, 0, 16'hFFFD, t + 32);
        wait_cyc(t + 50);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abandoned_queue_empty", 32'(sbq.size()), 0);
        chk("idle_after_reset", 32'(busy), 0);
        run(2, 0, 0, 0, t);
        push(16'hFFFD, 0, 16'hFFFD, t + 32);
        push(16'd2, 1, 16'hFFFF, t + 65);
        wait_done(t + 66);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
